sdram_hexdump_streamer: RTL and testbench
=========================================

Name: sdram_hexdump_streamer

Overview:
Bulk read-out stage between the SDRAM controller's command/read-data port and the UART transmitter. On a start pulse it issues sequential single-word reads from a start address and buffers the returned words in a small FIFO. It formats each word as 4 lowercase hex ASCII characters with space and CR/LF separators, and streams them byte-by-byte to the UART. This replaces one-word-per-command debug reads with whole-region dumps at the same 1.5 MHz system clock.

Parameters:
AddrWidth, 23, SDRAM word address width (cmdAddr).
DataWidth, 16, SDRAM word width; fixed 4 hex chars per word.
FifoDepth, 4, read-data FIFO entries (power of 2, >=2).
WordsPerLine, 8, words per output line before CR/LF (>=1).

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle start pulse; ignored while busy=1.
startAddr  in  AddrWidth  first word address; sampled when start is accepted.
wordCount  in  16  number of words to dump; sampled when start is accepted.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse when the final byte has been handed to the UART.
error  out  1  sticky: read data arrived with no outstanding read, or the FIFO overflowed; cleared by rst or an accepted start.
cmdReady  in  1  SDRAM controller ready.
cmdTrigger  out  1  SDRAM command request.
cmdWrite  out  1  constant 0.
cmdAddr  out  AddrWidth  read address.
cmdReadData  in  DataWidth  returned read data.
cmdReadDataValid  in  1  one-cycle valid strobe for cmdReadData.
uartTransmit  out  1  one-cycle pulse to send uartTxByte.
uartTxByte  out  8  byte to send; stable in the cycle uartTransmit=1.
uartTransmitting  in  1  UART busy.

Behaviour:
- Reset values: busy=0, done=0, error=0, cmdTrigger=0, cmdWrite=0, cmdAddr=0, uartTransmit=0, uartTxByte=0. FIFO empty, all counters 0.
- Reset mid-operation aborts the dump: no done pulse, and cmdTrigger=0 at the next edge.
- Start: accepted when start=1 and busy=0. Latches addr=startAddr, issueRemain=wordCount, fmtRemain=wordCount, lineCol=0; clears error.
- wordCount=0: no reads, no bytes; done=1 exactly one cycle after start is accepted; busy stays 0.
- Issue side, per command:
  - The block raises cmdTrigger with cmdAddr=addr only when issueRemain>0 and (fifoCount+outstanding)<FifoDepth. This reservation makes FIFO overflow impossible in correct operation.
  - A command is accepted in a cycle with cmdTrigger=1 and cmdReady=1.
  - On acceptance, the next edge deasserts cmdTrigger, increments outstanding, decrements issueRemain, and increments addr modulo 2^AddrWidth (0x7FFFFF wraps to 0x000000).
  - cmdAddr holds steady while cmdTrigger=1.
  - After acceptance the block keeps cmdTrigger=0 for at least one cycle before re-raising it. It then re-raises cmdTrigger only when the issue condition holds again.
- Return side, on cmdReadDataValid:
  - outstanding>0: push cmdReadData into the FIFO and decrement outstanding. A push and a pop in the same cycle are both honoured.
  - outstanding=0: drop the data and set error.
- Formatter FSM states: IDLE, HEX3, HEX2, HEX1, HEX0, SEP, CR, LF, DONE.
  - IDLE -> HEX3 when busy and the FIFO is non-empty; pops one word into a shift register.
  - Each HEXn sends nibble n as "0"-"9" or "a"-"f".
  - After HEX0, fmtRemain decrements. If the word was the last one or lineCol==WordsPerLine-1, go to CR, then LF, and reset lineCol to 0. Otherwise go to SEP (sends 0x20) and increment lineCol.
  - After LF or SEP: if fmtRemain>0 go to IDLE; else go to DONE.
  - DONE pulses done=1 for one cycle, clears busy, and returns to IDLE.
- UART rule: a byte is sent by driving uartTransmit=1 for one cycle, only in a cycle where uartTransmit=0 and uartTransmitting=0 at the prior edge. Hence no two consecutive uartTransmit cycles, and each byte is sent exactly once.
- start pulses arriving while busy=1 are ignored and do not disturb the dump in progress.

Decomposition:
- Package sdram_hexdump_pkg:
  - formatter state enum.
  - HexASCIIFromNibble function (lowercase).
  - constants ASCII_SP=0x20, ASCII_CR=0x0D, ASCII_LF=0x0A.
- Sub-module sdram_read_fifo: synchronous FIFO with FifoDepth/DataWidth parameters. Ports: push, pop, wdata, rdata, empty, full, count. Simultaneous push and pop is allowed when full or empty.

Test Plan:
- Basic dump: SDRAM preloaded with 0x1234, 0xabcd at 0x000010; startAddr=0x000010, wordCount=2. UART bytes must be "1234 abcd\r\n", followed by one done pulse. Two reads are issued at 0x000010 and 0x000011.
- Line wrap: WordsPerLine=8, wordCount=9, data 0x0000..0x0008. Output is 8 words separated by spaces, then "\r\n", then "0008\r\n".
- Backpressure: hold uartTransmitting high for long periods. fifoCount+outstanding never exceeds 4, error stays 0, and all 20 words arrive in address order.
- Address wrap: startAddr=0x7FFFFE, wordCount=4. Reads are issued at 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001.
- Edge cases:
  - wordCount=0: done one cycle after start, with no cmdTrigger and no uartTransmit.
  - start pulsed while busy: ignored, and the current output is unchanged.
  - cmdReadDataValid with outstanding=0: error=1 and the FIFO is unchanged.
- Reset mid-dump: assert rst during word 3 of 10. Next cycle cmdTrigger=0, uartTransmit=0 and busy=0, with no done pulse. A new start then dumps correctly with error=0.

Source files
------------

// File: rtl/sdram_hexdump_pkg.sv
// Shared types and helpers for the SDRAM hex-dump streamer.
package sdram_hexdump_pkg;

    // Formatter sequence: four hex digits per word, then a separator or line break.
    typedef enum logic [3:0] {
        IDLE,
        HEX3,
        HEX2,
        HEX1,
        HEX0,
        SEP,
        CR,
        LF,
        DONE
    } fmt_state_t;

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Lowercase ASCII hex digit for a nibble ("0"-"9", "a"-"f").
    function automatic logic [7:0] HexASCIIFromNibble(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return 8'h30 + {4'h0, nibble};
        end
        return 8'h57 + {4'h0, nibble};
    endfunction

endpackage

// File: rtl/sdram_read_fifo.sv
// Small synchronous FIFO buffering SDRAM read data ahead of the formatter.
// rdata shows the head entry whenever the FIFO is non-empty.
module sdram_read_fifo #(
    parameter int FifoDepth = 4,
    parameter int DataWidth = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DataWidth-1:0]       wdata,
    output logic [DataWidth-1:0]       rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(FifoDepth):0] count
);

    localparam int PtrWidth   = $clog2(FifoDepth);
    localparam int CountWidth = PtrWidth + 1;
    localparam logic [CountWidth-1:0] FULL_COUNT = CountWidth'(FifoDepth);

    logic [DataWidth-1:0] mem [FifoDepth];
    logic [PtrWidth-1:0]  rd_ptr;
    logic [PtrWidth-1:0]  wr_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage write; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PtrWidth'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PtrWidth'(1);
            end
            count <= count + CountWidth'(do_push) - CountWidth'(do_pop);
        end
    end

endmodule

// File: rtl/sdram_hexdump_streamer.sv
// Reads a region of SDRAM word by word and streams it to the UART as
// lowercase hex text, WordsPerLine words per line.
module sdram_hexdump_streamer #(
    parameter int AddrWidth    = 23,
    parameter int DataWidth    = 16,
    parameter int FifoDepth    = 4,
    parameter int WordsPerLine = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AddrWidth-1:0] startAddr,
    input  logic [15:0]          wordCount,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    input  logic                 cmdReady,
    output logic                 cmdTrigger,
    output logic                 cmdWrite,
    output logic [AddrWidth-1:0] cmdAddr,
    input  logic [DataWidth-1:0] cmdReadData,
    input  logic                 cmdReadDataValid,
    output logic                 uartTransmit,
    output logic [7:0]           uartTxByte,
    input  logic                 uartTransmitting
);

    import sdram_hexdump_pkg::*;

    localparam int CountWidth   = $clog2(FifoDepth) + 1;
    localparam int LineColWidth = (WordsPerLine > 1) ? $clog2(WordsPerLine) : 1;
    localparam logic [LineColWidth-1:0] LAST_COL = LineColWidth'(WordsPerLine - 1);
    localparam logic [CountWidth:0]     RESERVE_LIMIT = (CountWidth + 1)'(FifoDepth);

    fmt_state_t             state;
    fmt_state_t             state_next;
    logic [AddrWidth-1:0]   addr;
    logic [15:0]            issue_remain;
    logic [15:0]            fmt_remain;
    logic [LineColWidth-1:0] line_col;
    logic [CountWidth-1:0]  outstanding;
    logic [DataWidth-1:0]   word;

    logic                   start_accept;
    logic                   cmd_accept;
    logic                   can_send;
    logic                   send;
    logic [7:0]             send_byte;
    logic                   word_done;
    logic                   finish;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic [DataWidth-1:0]   fifo_rdata;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [CountWidth-1:0]  fifo_count;
    logic [CountWidth:0]    reserved;
    logic                   stray_data;
    logic                   overflow;

    assign cmdWrite     = 1'b0;
    assign cmdAddr      = addr;
    assign start_accept = start && !busy;
    assign cmd_accept   = cmdTrigger && cmdReady;
    assign can_send     = !uartTransmit && !uartTransmitting;
    assign fifo_push    = cmdReadDataValid && (outstanding != '0);
    assign stray_data   = cmdReadDataValid && (outstanding == '0);
    assign overflow     = fifo_push && fifo_full && !fifo_pop;
    assign reserved     = {1'b0, fifo_count} + {1'b0, outstanding};

    sdram_read_fifo #(
        .FifoDepth(FifoDepth),
        .DataWidth(DataWidth)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .pop  (fifo_pop),
        .wdata(cmdReadData),
        .rdata(fifo_rdata),
        .empty(fifo_empty),
        .full (fifo_full),
        .count(fifo_count)
    );

    // Formatter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Formatter next-state and byte selection; a byte leaves only when the UART path is free.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        send       = 1'b0;
        send_byte  = '0;
        word_done  = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (busy && !fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = HEX3;
                end
            end
            HEX3: begin
                send_byte = HexASCIIFromNibble(word[15:12]);
                if (can_send) begin
                    send       = 1'b1;
                    state_next = HEX2;
                end
            end
            HEX2: begin
                send_byte = HexASCIIFromNibble(word[11:8]);
                if (can_send) begin
                    send       = 1'b1;
                    state_next = HEX1;
                end
            end
            HEX1: begin
                send_byte = HexASCIIFromNibble(word[7:4]);
                if (can_send) begin
                    send       = 1'b1;
                    state_next = HEX0;
                end
            end
            HEX0: begin
                send_byte = HexASCIIFromNibble(word[3:0]);
                if (can_send) begin
                    send      = 1'b1;
                    word_done = 1'b1;
                    if (fmt_remain == 16'd1 || line_col == LAST_COL) begin
                        state_next = CR;
                    end else begin
                        state_next = SEP;
                    end
                end
            end
            SEP: begin
                send_byte = ASCII_SP;
                if (can_send) begin
                    send       = 1'b1;
                    state_next = (fmt_remain != '0) ? IDLE : DONE;
                end
            end
            CR: begin
                send_byte = ASCII_CR;
                if (can_send) begin
                    send       = 1'b1;
                    state_next = LF;
                end
            end
            LF: begin
                send_byte = ASCII_LF;
                if (can_send) begin
                    send       = 1'b1;
                    state_next = (fmt_remain != '0) ? IDLE : DONE;
                end
            end
            DONE: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Formatter datapath: current word, word/column counters and the UART byte register.
    always_ff @(posedge clk) begin
        if (rst) begin
            word         <= '0;
            fmt_remain   <= '0;
            line_col     <= '0;
            uartTransmit <= 1'b0;
            uartTxByte   <= '0;
        end else begin
            uartTransmit <= send;
            if (send) begin
                uartTxByte <= send_byte;
            end
            if (fifo_pop) begin
                word <= fifo_rdata;
            end
            if (start_accept) begin
                fmt_remain <= wordCount;
                line_col   <= '0;
            end else if (word_done) begin
                fmt_remain <= fmt_remain - 16'd1;
                line_col   <= (state_next == CR) ? '0 : line_col + LineColWidth'(1);
            end
        end
    end

    // Run control: busy window, done pulse and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_accept) begin
                error <= 1'b0;
                if (wordCount == '0) begin
                    done <= 1'b1;
                end else begin
                    busy <= 1'b1;
                end
            end
            if (finish) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
            if (stray_data || overflow) begin
                error <= 1'b1;
            end
        end
    end

    // Read issue: a command is raised only when a FIFO slot is reserved for its data;
    // acceptance always drops cmdTrigger for at least one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmdTrigger   <= 1'b0;
            addr         <= '0;
            issue_remain <= '0;
            outstanding  <= '0;
        end else begin
            if (start_accept) begin
                addr         <= startAddr;
                issue_remain <= wordCount;
            end else if (cmd_accept) begin
                cmdTrigger   <= 1'b0;
                addr         <= addr + AddrWidth'(1);
                issue_remain <= issue_remain - 16'd1;
            end else if (busy && !cmdTrigger && issue_remain != '0 && reserved < RESERVE_LIMIT) begin
                cmdTrigger <= 1'b1;
            end
            outstanding <= outstanding + CountWidth'(cmd_accept) - CountWidth'(fifo_push);
        end
    end

endmodule

// File: tb/tb_sdram_hexdump_streamer.sv
// Directed bench for sdram_hexdump_streamer with behavioural SDRAM and UART models.
module tb_sdram_hexdump_streamer;

    localparam int AW  = 23;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] startAddr = '0;
    logic [15:0]   wordCount = '0;
    logic          busy, done, error;
    logic          cmdReady = 1'b1;
    logic          cmdTrigger, cmdWrite;
    logic [AW-1:0] cmdAddr;
    logic [15:0]   cmdReadData = '0;
    logic          cmdReadDataValid = 1'b0;
    logic          uartTransmit;
    logic [7:0]    uartTxByte;
    logic          uartTransmitting = 1'b0;

    sdram_hexdump_streamer #(
        .AddrWidth(23),
        .DataWidth(16),
        .FifoDepth(4),
        .WordsPerLine(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .startAddr(startAddr), .wordCount(wordCount),
        .busy(busy), .done(done), .error(error),
        .cmdReady(cmdReady), .cmdTrigger(cmdTrigger), .cmdWrite(cmdWrite), .cmdAddr(cmdAddr),
        .cmdReadData(cmdReadData), .cmdReadDataValid(cmdReadDataValid),
        .uartTransmit(uartTransmit), .uartTxByte(uartTxByte), .uartTransmitting(uartTransmitting)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          due;
    } rd_t;

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    logic [15:0]   mem_a [logic [AW-1:0]];
    rd_t           pend[$];
    logic [7:0]    rx_q[$];
    logic [AW-1:0] addr_log[$];
    int            done_cnt = 0;
    int            trig_cnt = 0;
    int            b2b = 0;
    int            accepted = 0;
    int            hex_bytes = 0;
    int            max_inflight = 0;
    int            uart_delay = 0;
    int            ready_mode = 0;
    int            uart_cnt = 0;
    bit            prev_tx = 0;
    bit            inject_rdv = 0;

    function automatic logic [15:0] rd(input logic [AW-1:0] a);
        if (mem_a.exists(a)) return mem_a[a];
        return a[15:0] ^ 16'hc3a5;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // SDRAM and UART models, all activity on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pend.delete();
                uart_cnt = 0;
                uartTransmitting = 1'b0;
                cmdReadDataValid = 1'b0;
                prev_tx = 0;
            end else begin
                if (done) done_cnt++;
                if (cmdTrigger) trig_cnt++;
                if (uartTransmit) begin
                    rx_q.push_back(uartTxByte);
                    if (uartTxByte != 8'h20 && uartTxByte != 8'h0d && uartTxByte != 8'h0a) hex_bytes++;
                    if (prev_tx) b2b++;
                    uart_cnt = uart_delay;
                end
                prev_tx = uartTransmit;
                if (uart_cnt > 0) begin
                    uartTransmitting = 1'b1;
                    uart_cnt--;
                end else begin
                    uartTransmitting = 1'b0;
                end
                cmdReady = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
                if (cmdTrigger && cmdReady) begin
                    addr_log.push_back(cmdAddr);
                    pend.push_back('{data: rd(cmdAddr), due: cyc + LAT});
                    accepted++;
                end
                if (accepted - (hex_bytes + 3) / 4 > max_inflight)
                    max_inflight = accepted - (hex_bytes + 3) / 4;
                cmdReadDataValid = 1'b0;
                if (inject_rdv) begin
                    cmdReadDataValid = 1'b1;
                    cmdReadData = 16'hdead;
                    inject_rdv = 0;
                end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                    rd_t r;
                    r = pend.pop_front();
                    cmdReadDataValid = 1'b1;
                    cmdReadData = r.data;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rx_q.delete();
        addr_log.delete();
        trig_cnt = 0;
        b2b = 0;
        accepted = 0;
        hex_bytes = 0;
        max_inflight = 0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] a, input logic [15:0] n);
        start = 1'b1;
        startAddr = a;
        wordCount = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < limit) begin
            tick();
            n++;
        end
        if (done_cnt == d0) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic check_text(input string tag, input string exp);
        check({tag, "_len"}, rx_q.size(), exp.len());
        for (int i = 0; i < exp.len(); i++) begin
            logic [7:0] got;
            got = (i < rx_q.size()) ? rx_q[i] : 8'h00;
            check($sformatf("%s[%0d]", tag, i), got, exp[i]);
        end
    endtask

    task automatic check_addrs(input string tag, input logic [AW-1:0] base, input int n);
        check({tag, "_cnt"}, addr_log.size(), n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] got;
            got = (i < addr_log.size()) ? addr_log[i] : '1;
            check($sformatf("%s[%0d]", tag, i), got, base + AW'(i));
        end
    endtask

    function automatic string expect_text(input logic [AW-1:0] base, input int n);
        string s;
        s = "";
        for (int i = 0; i < n; i++) begin
            s = $sformatf("%s%04h", s, rd(base + AW'(i)));
            if (i == n - 1 || i % 8 == 7) s = {s, "\r\n"};
            else s = {s, " "};
        end
        return s;
    endfunction

    initial begin
        int d0;
        int n;

        mem_a[23'h000010] = 16'h1234;
        mem_a[23'h000011] = 16'habcd;
        for (int i = 0; i < 9; i++) mem_a[AW'(i)] = 16'(i);

        // Reset values
        rst = 1'b1;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_trig", cmdTrigger, 0);
        check("rst_write", cmdWrite, 0);
        check("rst_addr", cmdAddr, 0);
        check("rst_tx", uartTransmit, 0);
        check("rst_txbyte", uartTxByte, 0);
        rst = 1'b0;
        tick();

        // Basic two-word dump
        clear_logs();
        d0 = done_cnt;
        pulse_start(23'h000010, 16'd2);
        check("basic_busy", busy, 1);
        wait_done("basic", 500);
        check_text("basic_txt", "1234 abcd\r\n");
        check_addrs("basic_addr", 23'h000010, 2);
        repeat (10) tick();
        check("basic_done1", done_cnt, d0 + 1);
        check("basic_busy_end", busy, 0);
        check("basic_err", error, 0);
        check("basic_b2b", b2b, 0);

        // Line wrap after eight words
        clear_logs();
        pulse_start(23'h000000, 16'd9);
        wait_done("wrap", 1000);
        check_text("wrap_txt", "0000 0001 0002 0003 0004 0005 0006 0007\r\n0008\r\n");
        check_addrs("wrap_addr", 23'h000000, 9);

        // Backpressure: slow UART and random cmdReady
        clear_logs();
        uart_delay = 12;
        ready_mode = 1;
        pulse_start(23'h000100, 16'd20);
        wait_done("bp", 5000);
        check_text("bp_txt", expect_text(23'h000100, 20));
        check_addrs("bp_addr", 23'h000100, 20);
        check("bp_err", error, 0);
        check("bp_b2b", b2b, 0);
        check("bp_inflight_le5", (max_inflight <= 5) ? 1 : 0, 1);
        uart_delay = 0;
        ready_mode = 0;
        repeat (5) tick();

        // Address wrap at the top of the address space
        clear_logs();
        pulse_start(23'h7ffffe, 16'd4);
        wait_done("awrap", 1000);
        check("awrap_cnt", addr_log.size(), 4);
        check("awrap_a0", (addr_log.size() > 0) ? addr_log[0] : '1, 23'h7ffffe);
        check("awrap_a1", (addr_log.size() > 1) ? addr_log[1] : '1, 23'h7fffff);
        check("awrap_a2", (addr_log.size() > 2) ? addr_log[2] : '1, 23'h000000);
        check("awrap_a3", (addr_log.size() > 3) ? addr_log[3] : '1, 23'h000001);
        check_text("awrap_txt", expect_text(23'h7ffffe, 4));

        // wordCount = 0: done one cycle after accept, nothing issued or sent
        repeat (3) tick();
        clear_logs();
        d0 = done_cnt;
        pulse_start(23'h000020, 16'd0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        tick();
        check("zero_done_low", done, 0);
        repeat (5) tick();
        check("zero_done_cnt", done_cnt, d0 + 1);
        check("zero_trig", trig_cnt, 0);
        check("zero_tx", rx_q.size(), 0);

        // start while busy is ignored
        clear_logs();
        d0 = done_cnt;
        pulse_start(23'h000200, 16'd6);
        repeat (20) tick();
        pulse_start(23'h000300, 16'd3);
        wait_done("busy_start", 1000);
        repeat (10) tick();
        check_text("busy_start_txt", expect_text(23'h000200, 6));
        check_addrs("busy_start_addr", 23'h000200, 6);
        check("busy_start_done", done_cnt, d0 + 1);

        // Read data with nothing outstanding sets error and is dropped
        clear_logs();
        inject_rdv = 1;
        repeat (2) tick();
        check("stray_err", error, 1);
        pulse_start(23'h000600, 16'd1);
        check("stray_err_clr", error, 0);
        wait_done("stray", 500);
        check_text("stray_txt", expect_text(23'h000600, 1));

        // Reset during the third word of ten
        repeat (3) tick();
        clear_logs();
        uart_delay = 4;
        pulse_start(23'h000400, 16'd10);
        n = 0;
        while (rx_q.size() < 10 && n < 2000) begin
            tick();
            n++;
        end
        check("mid_reached", (rx_q.size() >= 10) ? 1 : 0, 1);
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        check("mid_trig", cmdTrigger, 0);
        check("mid_tx", uartTransmit, 0);
        check("mid_busy", busy, 0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("mid_no_done", done_cnt, d0);
        check("mid_idle_trig", trig_cnt >= 0 ? busy : 1'b1, 0);
        uart_delay = 0;
        clear_logs();
        pulse_start(23'h000500, 16'd3);
        wait_done("mid_restart", 1000);
        check_text("mid_restart_txt", expect_text(23'h000500, 3));
        check_addrs("mid_restart_addr", 23'h000500, 3);
        check("mid_restart_err", error, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
